fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: BOOT clears the PC, then alternates FETCH/EXEC
// and decodes the latched instruction into PC strobes and an ALU strobe.
module fetch_sequencer (
    input  logic        CLK,
    input  logic        CLB,
    input  logic [11:0] instr_in,
    input  logic        instr_valid,
    input  logic        zero_flag,
    output logic        imem_req,
    output logic        IncPC,
    output logic        LoadPC,
    output logic        SelPC,
    output logic [7:0]  A,
    output logic [3:0]  B,
    output logic [11:0] ir,
    output logic        alu_en,
    output logic [2:0]  alu_op,
    output logic        halted,
    output logic        illegal
);
    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t     state, state_nxt;
    logic [3:0] opcode;

    assign opcode = ir[11:8];

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) state <= S_BOOT;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            ir      <= 12'h000;
            illegal <= 1'b0;
        end else begin
            if (state == S_FETCH && instr_valid) ir <= instr_in;
            if (state == S_EXEC && (opcode == 4'hC || opcode == 4'hD || opcode == 4'hE))
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (instr_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (opcode == 4'hF) ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // Outputs depend on state and ir only; zero_flag enters solely through JZ.
    always_comb begin
        imem_req = 1'b0;
        IncPC    = 1'b0;
        LoadPC   = 1'b0;
        SelPC    = 1'b0;
        A        = 8'h00;
        B        = 4'h0;
        alu_en   = 1'b0;
        alu_op   = 3'd0;
        halted   = 1'b0;
        case (state)
            S_BOOT: begin
                IncPC  = 1'b1;
                LoadPC = 1'b1;
            end
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        IncPC  = 1'b1;
                        alu_en = 1'b1;
                        alu_op = ir[10:8];
                    end
                    4'h8: begin
                        LoadPC = 1'b1;
                        SelPC  = 1'b1;
                        A      = ir[7:0];
                    end
                    4'h9: begin
                        if (zero_flag) begin
                            LoadPC = 1'b1;
                            SelPC  = 1'b1;
                            A      = ir[7:0];
                        end else begin
                            IncPC  = 1'b1;
                        end
                    end
                    4'hA: begin
                        LoadPC = 1'b1;
                        B      = ir[3:0];
                    end
                    4'hB: begin
                        IncPC  = 1'b1;
                        LoadPC = 1'b1;
                    end
                    4'hF: ;
                    // NOP and the illegal opcodes both just step the PC
                    default: IncPC = 1'b1;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed program plus randomized instruction stream compared
// every cycle against a phase-level reference model of the sequencer.
module tb_fetch_sequencer;
    logic        CLK = 1'b0;
    logic        CLB = 1'b0;
    logic [11:0] instr_in = 12'h000;
    logic        instr_valid = 1'b0;
    logic        zero_flag = 1'b0;
    logic        imem_req, IncPC, LoadPC, SelPC, alu_en, halted, illegal;
    logic [7:0]  A;
    logic [3:0]  B;
    logic [11:0] ir;
    logic [2:0]  alu_op;

    fetch_sequencer dut (
        .CLK(CLK), .CLB(CLB), .instr_in(instr_in), .instr_valid(instr_valid),
        .zero_flag(zero_flag), .imem_req(imem_req), .IncPC(IncPC), .LoadPC(LoadPC),
        .SelPC(SelPC), .A(A), .B(B), .ir(ir), .alu_en(alu_en), .alu_op(alu_op),
        .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // model: phase 0 = boot, 1 = waiting for instruction, 2 = executing, 3 = stopped
    int          m_phase = 0;
    logic [11:0] m_ir    = 12'h000;
    logic        m_ill   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // {imem_req, IncPC, LoadPC, SelPC, A, B, alu_en, alu_op, halted}
    function automatic logic [20:0] exp_outs(input int ph, input logic [11:0] ins, input logic z);
        logic req = 0, inc = 0, ld = 0, sel = 0, aen = 0, hlt = 0;
        logic [7:0] a = 0;
        logic [3:0] b = 0;
        logic [2:0] aop = 0;
        int op = int'(ins[11:8]);
        if (ph == 0) begin
            inc = 1; ld = 1;
        end else if (ph == 1) begin
            req = 1;
        end else if (ph == 3) begin
            hlt = 1;
        end else begin
            if (op == 0 || (op >= 12 && op <= 14)) inc = 1;
            else if (op <= 7) begin inc = 1; aen = 1; aop = 3'(op); end
            else if (op == 8 || (op == 9 && z)) begin ld = 1; sel = 1; a = ins[7:0]; end
            else if (op == 9) inc = 1;
            else if (op == 10) begin ld = 1; b = ins[3:0]; end
            else if (op == 11) begin inc = 1; ld = 1; end
        end
        return {req, inc, ld, sel, a, b, aen, aop, hlt};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".outs"}, 32'({imem_req, IncPC, LoadPC, SelPC, A, B, alu_en, alu_op, halted}),
            32'(exp_outs(m_phase, m_ir, zero_flag)));
        chk({tag, ".ir"}, 32'(ir), 32'(m_ir));
        chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
    endtask

    task automatic model_step();
        case (m_phase)
            0: m_phase = 1;
            1: if (instr_valid) begin m_ir = instr_in; m_phase = 2; end
            2: begin
                if (m_ir[11:8] >= 4'hC && m_ir[11:8] <= 4'hE) m_ill = 1;
                m_phase = (m_ir[11:8] == 4'hF) ? 3 : 1;
            end
            default: ;
        endcase
    endtask

    // entered just after a rising edge; leaves just after the next one
    task automatic cycle(input string tag, input logic v, input logic [11:0] ins, input logic z);
        instr_valid = v;
        instr_in    = ins;
        zero_flag   = z;
        @(negedge CLK);
        check_all(tag);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        instr_valid = 1'b1;
        instr_in    = 12'h123;
        CLB = 1'b0;
        m_phase = 0; m_ir = 12'h000; m_ill = 1'b0;
        #1 check_all("rst_async");
        @(posedge CLK);
        #1;
        @(negedge CLK);
        CLB = 1'b1;
        #1 check_all("rst_boot");
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic exec_instr(input string tag, input logic [11:0] ins, input logic z);
        cycle({tag, "_fetch"}, 1'b1, ins, z);
        cycle({tag, "_exec"}, 1'b1, 12'hFFF, z);  // valid during EXEC must be ignored
    endtask

    initial begin
        #1 check_all("por");
        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < 3; i++) cycle("wait", 1'b0, 12'hABC, 1'b1);
        exec_instr("nop", 12'h000, 1'b0);
        exec_instr("alu", 12'h305, 1'b0);
        exec_instr("jmp", 12'h842, 1'b0);
        exec_instr("br", 12'hA07, 1'b0);
        exec_instr("jz0", 12'h910, 1'b0);
        exec_instr("jz1", 12'h910, 1'b1);
        exec_instr("ill", 12'hC00, 1'b0);
        exec_instr("nop2", 12'h000, 1'b0);
        exec_instr("rstpc", 12'hB00, 1'b0);
        exec_instr("halt", 12'hF00, 1'b0);
        for (int i = 0; i < 12; i++) cycle("halted", 1'b1, 12'h305, 1'b1);
        chk("halted_flag", 32'(halted), 32'(1));

        // reset in the middle of an EXEC abandons the instruction
        cycle("pre_exec", 1'b1, 12'h842, 1'b0);
        do_reset();
        chk("post_rst_halted", 32'(halted), 32'(0));
        chk("post_rst_illegal", 32'(illegal), 32'(0));

        for (int i = 0; i < 800; i++) begin
            logic [11:0] ins = 12'($urandom);
            if (m_phase == 3 && $urandom_range(0, 7) == 0) do_reset();
            else cycle("rand", 1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
